ibex_mult_pext_sequencer: RTL and testbench
===========================================

# ibex_mult_pext_sequencer

Registered control sequencer for the P-extension multiplier datapath. It accepts one decoded multiplier operation at a time: mode, cycle count, accumulate, subtract, crossed and dual-sum flags. It then steps the datapath through a parametrised number of partial-product cycles, adds an optional ALU accumulation cycle, and holds the result-valid handshake until the consumer accepts it. It sits between the P-ext decode helper and the multiplier/ALU datapath in the EX stage, and supports lane counts and cycle depths beyond the fixed 1/2/3-cycle scheme.

## Interface
Parameters:
- MaxCycles, 4: maximum number of multiplier cycles per op (≥2).
- NumLanes, 4: number of 8-bit multiplier lanes driven by `lane_en_o`.
- CntW, $clog2(MaxCycles): cycle counter width (derived; do not override).

Ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- start_i  in  1  op request; accepted when `start_i & ready_o`.
- ready_o  out  1  sequencer can accept an op this cycle.
- mode_i  in  mult_pext_mode_e  M8x8/M16x16/M32x16/M32x32.
- cycles_m1_i  in  CntW  multiplier cycles minus one.
- accum_i  in  1  append an ALU accumulation cycle.
- accum_sub_i  in  2  [sub in 32x32, sub in 32x16].
- crossed_i  in  1  operand-crossed op.
- dsum_i  in  1  dual-sum (lane products summed) op.
- kill_i  in  1  flush: abort the current op.
- busy_o  out  1  state ≠ IDLE.
- cycle_o  out  CntW  current multiplier cycle index.
- b_hi_o  out  1  select B high halfword for this cycle.
- shift16_o  out  1  shift partial product left by 16.
- lane_en_o  out  NumLanes  active multiplier lanes.
- pp_accum_o  out  1  add partial product into the internal accumulator (not the first cycle).
- sub_o  out  1  subtract on the accumulate/dual-sum path.
- dsum_o  out  1  registered dual-sum flag.
- alu_accum_o  out  1  ALU accumulation cycle active.
- valid_o  out  1  result valid.
- result_ready_i  in  1  consumer accepts the result.

## Operation
- States: IDLE, MULT, ACCUM, DONE. The enum lives in the shared package.
- **IDLE.** `ready_o = 1`. On accept:
  - Latch all op inputs.
  - `cnt <= 0`, then go to MULT.
  - If `cycles_m1_i ≥ MaxCycles`, clamp it to MaxCycles-1.
- **MULT.**
  - `cycle_o = cnt`.
  - `pp_accum_o = (cnt ≠ 0)`.
  - `b_hi_o`:
    - M32x32: `cnt[0] ^ crossed_q`.
    - M32x16: `crossed_q`.
    - Otherwise: 0.
  - `shift16_o = cnt[0]`, M32x32 only.
  - `lane_en_o`:
    - M8x8: all ones.
    - M16x16: pairs, i.e. all ones.
    - M32x16/M32x32: lanes [1:0] only.
  - When `cnt == cycles_m1_q`, go to ACCUM if `accum_q`, else to DONE. Otherwise `cnt++`.
- **ACCUM.** One cycle with `alu_accum_o = 1`, then DONE.
- **DONE.**
  - `valid_o = 1`; it is held until `result_ready_i`.
  - `ready_o = result_ready_i`, so back-to-back ops are allowed: `result_ready_i & start_i` latches the new op and goes straight to MULT.
  - `result_ready_i` without `start_i` returns to IDLE.
- **sub_o**:
  - M32x32: `accum_sub_q[1]`.
  - Otherwise: `accum_sub_q[0]`.
  - Valid in MULT and ACCUM; 0 elsewhere.
- **Masking.** All datapath-control outputs are 0 outside MULT/ACCUM, except `dsum_o`, which follows the latched flag while busy.
- **kill_i.** Takes priority over every transition. The next state is IDLE, the counter clears, and the registered flags are left stale but masked. A start in the same cycle as `kill_i` is not accepted: `ready_o` is forced to 0 while `kill_i` is high.

## Timing
- Accept edge at t.
- MULT occupies t+1 … t+N, where N = `cycles_m1_q` + 1.
- ACCUM occupies t+N+1 if `accum_q` is set.
- `valid_o` rises the following cycle.
- Latency to `valid_o`: N+1 cycles without accum, N+2 with accum.
- All outputs are from registers or registered-state decode; there is no combinational path from the op inputs to the outputs. `ready_o` depends combinationally on `result_ready_i` and `kill_i`.
- Reset values:
  - State IDLE, `cnt = 0`, all latched flags 0.
  - Outputs: `ready_o = 1`; every other output 0.
- Reset is asserted asynchronously mid-op; all state clears immediately with no partial result.

## Structure
- Add to the `ibex_pkg_pext` package: the `mult_seq_state_e` enum and a `mult_seq_op_t` struct (mode, cycles_m1, accum, accum_sub, crossed, dsum) used by both the decode helper and this block.
- No sub-module. A single file with a state register, counter and op register.

## Test plan
- M16x16, `cycles_m1 = 0`, `accum = 0`, accepted at cycle 0 → MULT at cycle 1 with `lane_en_o = 4'b1111`; `valid_o` at cycle 2; `result_ready_i = 1` → IDLE at cycle 3.
- M32x32, `cycles_m1 = 1`, `crossed = 0`, `accum = 1`, `accum_sub = 2'b10` →
  - `b_hi_o` / `shift16_o` = 0/0, then 1/1.
  - `alu_accum_o` at cycle 3, `sub_o = 1` throughout.
  - `valid_o` at cycle 4.
- M32x16, `crossed = 1`, `accum_sub = 2'b01` → `b_hi_o = 1`, `sub_o = 1` for one MULT cycle; `lane_en_o = 4'b0011`.
- `result_ready_i` held low for 3 cycles in DONE → `valid_o` stays high; then `result_ready_i & start_i` in the same cycle → the new op goes to MULT the next cycle with no IDLE bubble.
- `kill_i` during MULT cycle 2 of a 4-cycle op → IDLE next cycle, `valid_o` never asserted; a `start_i` in the kill cycle is not accepted.
- `cycles_m1_i = MaxCycles+1` (out of range for the parameter) → clamped to exactly MaxCycles MULT cycles; `rst_i` pulsed mid-MULT → all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/ibex_pkg_pext.sv
// Shared P-extension types: multiplier modes, sequencer states and the decoded
// multiplier op handed from the decode helper to the sequencer.
package ibex_pkg_pext;

  typedef enum logic [1:0] {
    M8x8   = 2'd0,
    M16x16 = 2'd1,
    M32x16 = 2'd2,
    M32x32 = 2'd3
  } mult_pext_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULT  = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } mult_seq_state_e;

  // Wide enough for any cycle depth this block is built with.
  localparam int unsigned MultSeqCyclesW = 8;

  typedef struct packed {
    mult_pext_mode_e             mode;
    logic [MultSeqCyclesW-1:0]   cycles_m1;
    logic                        accum;
    logic [1:0]                  accum_sub;
    logic                        crossed;
    logic                        dsum;
  } mult_seq_op_t;

endpackage

// File: rtl/ibex_mult_pext_sequencer.sv
// Control sequencer for the P-ext multiplier: steps partial-product cycles,
// an optional ALU accumulate cycle, and holds result-valid until consumed.
module ibex_mult_pext_sequencer
  import ibex_pkg_pext::*;
#(
  parameter int unsigned MaxCycles = 4,
  parameter int unsigned NumLanes  = 4,
  parameter int unsigned CntW      = $clog2(MaxCycles)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  output logic                ready_o,
  input  mult_pext_mode_e     mode_i,
  input  logic [CntW-1:0]     cycles_m1_i,
  input  logic                accum_i,
  input  logic [1:0]          accum_sub_i,
  input  logic                crossed_i,
  input  logic                dsum_i,
  input  logic                kill_i,
  output logic                busy_o,
  output logic [CntW-1:0]     cycle_o,
  output logic                b_hi_o,
  output logic                shift16_o,
  output logic [NumLanes-1:0] lane_en_o,
  output logic                pp_accum_o,
  output logic                sub_o,
  output logic                dsum_o,
  output logic                alu_accum_o,
  output logic                valid_o,
  input  logic                result_ready_i
);

  mult_seq_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  mult_seq_op_t    op_q, op_d;

  logic            accept;
  logic            last_cycle;
  logic            in_mult;
  logic            in_accum;
  logic [CntW-1:0] cycles_clamped;
  mult_seq_op_t    new_op;

  // Widen before comparing so a power-of-two MaxCycles does not wrap to zero.
  always_comb begin
    cycles_clamped = cycles_m1_i;
    if (32'(cycles_m1_i) >= MaxCycles) begin
      cycles_clamped = CntW'(MaxCycles - 1);
    end
    new_op = '{mode:      mode_i,
               cycles_m1: MultSeqCyclesW'(cycles_clamped),
               accum:     accum_i,
               accum_sub: accum_sub_i,
               crossed:   crossed_i,
               dsum:      dsum_i};
  end

  always_comb begin
    ready_o = 1'b0;
    case (state_q)
      IDLE:    ready_o = ~kill_i;
      DONE:    ready_o = result_ready_i & ~kill_i;
      default: ready_o = 1'b0;
    endcase
  end

  assign accept     = start_i & ready_o;
  assign last_cycle = (MultSeqCyclesW'(cnt_q) == op_q.cycles_m1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = MULT;
          cnt_d   = '0;
          op_d    = new_op;
        end
      end
      MULT: begin
        if (last_cycle) begin
          state_d = op_q.accum ? ACCUM : DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACCUM: state_d = DONE;
      DONE: begin
        if (accept) begin
          state_d = MULT;
          cnt_d   = '0;
          op_d    = new_op;
        end else if (result_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush wins; the op register keeps stale flags, masked by IDLE.
    if (kill_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      op_d    = op_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    in_mult     = (state_q == MULT);
    in_accum    = (state_q == ACCUM);
    busy_o      = (state_q != IDLE);
    valid_o     = (state_q == DONE);
    alu_accum_o = in_accum;
    cycle_o     = in_mult ? cnt_q : '0;
    pp_accum_o  = in_mult & (cnt_q != '0);
    shift16_o   = in_mult & (op_q.mode == M32x32) & cnt_q[0];
    dsum_o      = busy_o & op_q.dsum;
    b_hi_o      = 1'b0;
    lane_en_o   = '0;
    if (in_mult) begin
      case (op_q.mode)
        M32x32: begin
          b_hi_o    = cnt_q[0] ^ op_q.crossed;
          lane_en_o = NumLanes'(2'b11);
        end
        M32x16: begin
          b_hi_o    = op_q.crossed;
          lane_en_o = NumLanes'(2'b11);
        end
        default: lane_en_o = '1;
      endcase
    end
    sub_o = (in_mult | in_accum) &
            ((op_q.mode == M32x32) ? op_q.accum_sub[1] : op_q.accum_sub[0]);
  end

endmodule

// File: tb/tb_ibex_mult_pext_sequencer.sv
// Self-checking bench: directed scenarios then random traffic, each cycle
// compared against a schedule-queue reference model of the sequencer.
module tb_ibex_mult_pext_sequencer;
  import ibex_pkg_pext::*;

  localparam int unsigned MaxCycles = 5;
  localparam int unsigned NumLanes  = 4;
  localparam int unsigned CntW      = $clog2(MaxCycles);
  localparam int unsigned OutW      = 10 + CntW + NumLanes;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                start_i;
  logic                ready_o;
  mult_pext_mode_e     mode_i;
  logic [CntW-1:0]     cycles_m1_i;
  logic                accum_i;
  logic [1:0]          accum_sub_i;
  logic                crossed_i;
  logic                dsum_i;
  logic                kill_i;
  logic                busy_o;
  logic [CntW-1:0]     cycle_o;
  logic                b_hi_o;
  logic                shift16_o;
  logic [NumLanes-1:0] lane_en_o;
  logic                pp_accum_o;
  logic                sub_o;
  logic                dsum_o;
  logic                alu_accum_o;
  logic                valid_o;
  logic                result_ready_i;

  ibex_mult_pext_sequencer #(
    .MaxCycles(MaxCycles),
    .NumLanes (NumLanes)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .ready_o       (ready_o),
    .mode_i        (mode_i),
    .cycles_m1_i   (cycles_m1_i),
    .accum_i       (accum_i),
    .accum_sub_i   (accum_sub_i),
    .crossed_i     (crossed_i),
    .dsum_i        (dsum_i),
    .kill_i        (kill_i),
    .busy_o        (busy_o),
    .cycle_o       (cycle_o),
    .b_hi_o        (b_hi_o),
    .shift16_o     (shift16_o),
    .lane_en_o     (lane_en_o),
    .pp_accum_o    (pp_accum_o),
    .sub_o         (sub_o),
    .dsum_o        (dsum_o),
    .alu_accum_o   (alu_accum_o),
    .valid_o       (valid_o),
    .result_ready_i(result_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef enum {PhIdle, PhMult, PhAccum, PhDone} ph_kind_e;
  typedef struct {
    ph_kind_e kind;
    int       idx;
  } phase_t;
  typedef logic [OutW-1:0] outv_t;

  // Pending phases of the op in flight; empty means the sequencer is idle.
  phase_t       exp_q[$];
  mult_seq_op_t model_op;
  int           checks = 0;
  int           errors = 0;

  function automatic mult_seq_op_t mk_op(mult_pext_mode_e m, int cyc, logic acc,
                                         logic [1:0] as, logic cr, logic ds);
    mult_seq_op_t op;
    op.mode      = m;
    op.cycles_m1 = MultSeqCyclesW'(cyc);
    op.accum     = acc;
    op.accum_sub = as;
    op.crossed   = cr;
    op.dsum      = ds;
    return op;
  endfunction

  function automatic outv_t pack_dut();
    return {ready_o, busy_o, cycle_o, b_hi_o, shift16_o, lane_en_o,
            pp_accum_o, sub_o, dsum_o, alu_accum_o, valid_o};
  endfunction

  function automatic outv_t model_out(phase_t ph, mult_seq_op_t op, logic rr, logic kl);
    logic                rdy, bsy, bh, sh, ppa, sb, ds, aa, vl;
    logic [CntW-1:0]     cyc;
    logic [NumLanes-1:0] le;
    logic                is_m, is_a, odd, wide;
    is_m = (ph.kind == PhMult);
    is_a = (ph.kind == PhAccum);
    odd  = (ph.idx % 2) == 1;
    wide = (op.mode == M32x16) || (op.mode == M32x32);
    rdy  = (ph.kind == PhIdle) ? !kl : (ph.kind == PhDone) ? (rr && !kl) : 1'b0;
    bsy  = (ph.kind != PhIdle);
    cyc  = is_m ? CntW'(ph.idx) : '0;
    bh   = 1'b0;
    if (is_m && op.mode == M32x32) bh = odd ^ op.crossed;
    if (is_m && op.mode == M32x16) bh = op.crossed;
    sh   = is_m && (op.mode == M32x32) && odd;
    le   = '0;
    if (is_m) begin
      if (wide) le[1:0] = 2'b11;
      else      le      = '1;
    end
    ppa  = is_m && (ph.idx != 0);
    sb   = (is_m || is_a) && ((op.mode == M32x32) ? op.accum_sub[1] : op.accum_sub[0]);
    ds   = bsy && op.dsum;
    aa   = is_a;
    vl   = (ph.kind == PhDone);
    return {rdy, bsy, cyc, bh, sh, le, ppa, sb, ds, aa, vl};
  endfunction

  task automatic checkOutput(string tag, outv_t obs, outv_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare, then advance the model past the edge.
  task automatic applyStimulus(string tag, logic st, mult_seq_op_t op, logic rr, logic kl);
    phase_t cur;
    logic   acc_ok;
    int     n;
    @(negedge clk_i);
    start_i        = st;
    mode_i         = op.mode;
    cycles_m1_i    = op.cycles_m1[CntW-1:0];
    accum_i        = op.accum;
    accum_sub_i    = op.accum_sub;
    crossed_i      = op.crossed;
    dsum_i         = op.dsum;
    result_ready_i = rr;
    kill_i         = kl;
    #1;
    cur = '{PhIdle, 0};
    if (exp_q.size() > 0) cur = exp_q[0];
    checkOutput(tag, pack_dut(), model_out(cur, model_op, rr, kl));
    if (kl) begin
      exp_q.delete();
    end else begin
      acc_ok = 1'b0;
      case (cur.kind)
        PhIdle: acc_ok = st;
        PhDone: if (rr) begin
          void'(exp_q.pop_front());
          acc_ok = st;
        end
        default: void'(exp_q.pop_front());
      endcase
      if (acc_ok) begin
        model_op = op;
        n = int'(op.cycles_m1[CntW-1:0]) + 1;
        if (n > int'(MaxCycles)) n = MaxCycles;
        for (int i = 0; i < n; i++) exp_q.push_back('{PhMult, i});
        if (op.accum) exp_q.push_back('{PhAccum, 0});
        exp_q.push_back('{PhDone, 0});
      end
    end
  endtask

  task automatic resetPulse(string tag);
    @(negedge clk_i);
    start_i        = 1'b0;
    kill_i         = 1'b0;
    result_ready_i = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    exp_q.delete();
    model_op = '0;
    checkOutput(tag, pack_dut(), model_out('{PhIdle, 0}, model_op, 1'b0, 1'b0));
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    mult_seq_op_t op, op2, idle_op;
    idle_op = '0;
    model_op = '0;
    rst_i = 1'b1;
    start_i = 1'b0;
    mode_i = M8x8;
    cycles_m1_i = '0;
    accum_i = 1'b0;
    accum_sub_i = 2'b00;
    crossed_i = 1'b0;
    dsum_i = 1'b0;
    kill_i = 1'b0;
    result_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    checkOutput("reset_state", pack_dut(), model_out('{PhIdle, 0}, model_op, 1'b0, 1'b0));
    @(negedge clk_i);
    rst_i = 1'b0;

    op = mk_op(M16x16, 0, 1'b0, 2'b00, 1'b0, 1'b1);
    applyStimulus("m16_accept", 1'b1, op, 1'b0, 1'b0);
    applyStimulus("m16_mult", 1'b0, op, 1'b0, 1'b0);
    applyStimulus("m16_done", 1'b0, op, 1'b1, 1'b0);
    applyStimulus("m16_idle", 1'b0, idle_op, 1'b0, 1'b0);

    op = mk_op(M32x32, 1, 1'b1, 2'b10, 1'b0, 1'b0);
    applyStimulus("m32_accept", 1'b1, op, 1'b0, 1'b0);
    applyStimulus("m32_mult0", 1'b0, op, 1'b0, 1'b0);
    applyStimulus("m32_mult1", 1'b0, op, 1'b0, 1'b0);
    applyStimulus("m32_accum", 1'b0, op, 1'b0, 1'b0);
    applyStimulus("m32_done", 1'b0, op, 1'b1, 1'b0);

    op = mk_op(M32x16, 0, 1'b0, 2'b01, 1'b1, 1'b0);
    applyStimulus("m3216_accept", 1'b1, op, 1'b0, 1'b0);
    applyStimulus("m3216_mult", 1'b0, op, 1'b0, 1'b0);
    applyStimulus("m3216_done", 1'b0, op, 1'b1, 1'b0);

    op  = mk_op(M8x8, 2, 1'b0, 2'b00, 1'b0, 1'b1);
    op2 = mk_op(M32x32, 0, 1'b0, 2'b11, 1'b1, 1'b0);
    applyStimulus("hold_accept", 1'b1, op, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("hold_mult", 1'b0, op, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("hold_done_wait", 1'b0, op, 1'b0, 1'b0);
    applyStimulus("b2b_accept", 1'b1, op2, 1'b1, 1'b0);
    applyStimulus("b2b_mult", 1'b0, op2, 1'b0, 1'b0);
    applyStimulus("b2b_done", 1'b0, op2, 1'b1, 1'b0);

    op = mk_op(M8x8, 3, 1'b1, 2'b01, 1'b0, 1'b1);
    applyStimulus("kill_accept", 1'b1, op, 1'b0, 1'b0);
    applyStimulus("kill_mult0", 1'b0, op, 1'b0, 1'b0);
    applyStimulus("kill_mult1", 1'b0, op, 1'b0, 1'b0);
    applyStimulus("kill_cycle", 1'b1, op, 1'b0, 1'b1);
    applyStimulus("kill_idle", 1'b0, idle_op, 1'b0, 1'b0);
    applyStimulus("kill_idle2", 1'b0, idle_op, 1'b1, 1'b0);

    op = mk_op(M32x32, MaxCycles + 1, 1'b0, 2'b10, 1'b1, 1'b0);
    applyStimulus("clamp_accept", 1'b1, op, 1'b0, 1'b0);
    for (int i = 0; i < int'(MaxCycles); i++) applyStimulus("clamp_mult", 1'b0, op, 1'b0, 1'b0);
    applyStimulus("clamp_done", 1'b0, op, 1'b1, 1'b0);

    op = mk_op(M16x16, 3, 1'b1, 2'b11, 1'b0, 1'b1);
    applyStimulus("rst_accept", 1'b1, op, 1'b0, 1'b0);
    applyStimulus("rst_mult0", 1'b0, op, 1'b0, 1'b0);
    resetPulse("rst_mid_mult");
    applyStimulus("rst_after", 1'b0, idle_op, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      op = mk_op(mult_pext_mode_e'($urandom_range(3)), int'($urandom_range(7)),
                 1'($urandom_range(1)), 2'($urandom_range(3)),
                 1'($urandom_range(1)), 1'($urandom_range(1)));
      applyStimulus("random", 1'($urandom_range(1)), op, 1'($urandom_range(1)),
                    ($urandom_range(15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
